// File: rtl/digit_stream_tx_if.sv
// rtl/digit_stream_tx_if.sv - request/status bundle between a digit streamer and its client
interface digit_stream_tx_if #(
    parameter int DIGIT_W = 4
);
    logic [31:0]        num;
    logic               enabled;
    logic               abort;
    logic [DIGIT_W-1:0] out;
    logic               controlOut;
    logic               busy;
    logic               done;

    modport master (
        output num, enabled, abort,
        input  out, controlOut, busy, done
    );

    modport slave (
        input  num, enabled, abort,
        output out, controlOut, busy, done
    );
endinterface

// File: rtl/digit_stream_tx.sv
// rtl/digit_stream_tx.sv - serial BCD digit streamer, define DIGIT_STREAM_LZ_SUPPRESS_EN to stop after the top nonzero digit
module digit_stream_tx #(
    parameter int NUM_DIGITS  = 6,
    parameter int DIGIT_W     = 4,
    parameter int HOLD_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 1200000
) (
    input logic              hwclk,
    input logic              rst,
    digit_stream_tx_if.slave bus
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [3:0]       LAST_DIGIT = 4'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic               prev_en_q;
    logic [31:0]        bin_q, bin_d;
    logic [39:0]        bcd_q, bcd_d;
    logic [39:0]        bcd_adj;
    logic [5:0]         conv_cnt_q, conv_cnt_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [3:0]         k_q, k_d;
    logic [DIGIT_W-1:0] out_q, out_d;
    logic               ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start;
    logic               leave_digit;
    logic [3:0]         last_idx;
    logic [3:0]         next_digit;

    assign start = bus.enabled && !prev_en_q;

    // Add-3 correction on every BCD nibble ahead of the next left shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Index of the final digit to send in this transfer
    always_comb begin
`ifdef DIGIT_STREAM_LZ_SUPPRESS_EN
        last_idx = 4'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                last_idx = 4'(i);
            end
        end
`else
        last_idx = LAST_DIGIT;
`endif
    end

    // Digit that follows the one currently on the bus
    always_comb begin
        next_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k_q + 4'd1 == 4'(i)) begin
                next_digit = bcd_q[i*4 +: 4];
            end
        end
    end

    // Next-state and next-output logic; abort outranks everything outside IDLE
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        conv_cnt_d  = conv_cnt_q;
        tcnt_d      = tcnt_q;
        k_d         = k_q;
        out_d       = out_q;
        ctrl_d      = ctrl_q;
        busy_d      = busy_q;
        done_d      = done_q;
        leave_digit = 1'b0;

        if (state_q != IDLE && bus.abort) begin
            state_d    = IDLE;
            out_d      = '0;
            ctrl_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            k_d        = 4'd0;
            tcnt_d     = '0;
            conv_cnt_d = 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_d      = bus.num;
                        bcd_d      = '0;
                        conv_cnt_d = 6'd0;
                        k_d        = 4'd0;
                        tcnt_d     = '0;
                        out_d      = '0;
                        ctrl_d     = 1'b0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        state_d    = CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_cnt_q == 6'd32) begin
                        state_d = HOLD;
                        tcnt_d  = '0;
                        ctrl_d  = 1'b1;
                        out_d   = bcd_q[DIGIT_W-1:0];
                    end else begin
                        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                        conv_cnt_d     = conv_cnt_q + 6'd1;
                    end
                end
                HOLD: begin
                    if (tcnt_q == HOLD_LAST) begin
                        tcnt_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            ctrl_d  = 1'b0;
                        end else begin
                            leave_digit = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (tcnt_q == GAP_LAST) begin
                        leave_digit = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (leave_digit) begin
                tcnt_d = '0;
                if (k_q == last_idx) begin
                    state_d = IDLE;
                    out_d   = '0;
                    ctrl_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    k_d     = 4'd0;
                end else begin
                    state_d = HOLD;
                    k_d     = k_q + 4'd1;
                    ctrl_d  = 1'b1;
                    out_d   = next_digit[DIGIT_W-1:0];
                end
            end
        end
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_en_q  <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            conv_cnt_q <= 6'd0;
            tcnt_q     <= '0;
            k_q        <= 4'd0;
            out_q      <= '0;
            ctrl_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_en_q  <= bus.enabled;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            conv_cnt_q <= conv_cnt_d;
            tcnt_q     <= tcnt_d;
            k_q        <= k_d;
            out_q      <= out_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.controlOut = ctrl_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_digit_stream_tx.sv
// tb/tb_digit_stream_tx.sv - directed self-checking bench for digit_stream_tx
module tb_digit_stream_tx;
    localparam int ND = 6;
    localparam int DW = 4;
    localparam int HC = 4;
    localparam int GC = 2;
`ifdef DIGIT_STREAM_LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic hwclk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    digit_stream_tx_if #(.DIGIT_W(DW)) ifc ();
    digit_stream_tx_if #(.DIGIT_W(3))  ifc3 ();

    digit_stream_tx #(.NUM_DIGITS(ND), .DIGIT_W(DW), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)) dut (
        .hwclk(hwclk),
        .rst  (rst),
        .bus  (ifc.slave)
    );

    digit_stream_tx #(.NUM_DIGITS(ND), .DIGIT_W(3), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)) dut3 (
        .hwclk(hwclk),
        .rst  (rst),
        .bus  (ifc3.slave)
    );

    always #5 hwclk = ~hwclk;

    task automatic run_xfer(input string name, input logic [31:0] n, input logic [39:0] exp_digits,
                            input int exp_cnt, input int exp_done, input bit rel_rst, input bit toggle_en);
        int   ndig = 0;
        int   hi_len = 0;
        int   lo_len = 0;
        int   done_at = -1;
        logic pc = 1'b0;
        logic pb = 1'b0;
        logic [3:0] ed;
        if (!rel_rst) begin
            @(negedge hwclk); ifc.enabled = 1'b0;
        end
        @(negedge hwclk);
        rst = 1'b0; ifc.num = n; ifc.enabled = 1'b1;
        for (int cyc = 0; cyc < 200 && done_at < 0; cyc++) begin
            @(posedge hwclk); #1;
            if (cyc == 0) begin
                tests++;
                if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
                    fails++; $display("FAIL %s start: busy=%b done=%b expected busy=1 done=0", name, ifc.busy, ifc.done);
                end
            end
            if (cyc == 16) begin
                tests++;
                if (ifc.out !== 4'd0 || ifc.controlOut !== 1'b0) begin
                    fails++; $display("FAIL %s convert: out=%0d ctrl=%b expected 0 0", name, ifc.out, ifc.controlOut);
                end
            end
            if (ifc.controlOut) begin
                if (!pc) begin
                    if (ndig > 0) begin
                        tests++;
                        if (lo_len != GC) begin
                            fails++; $display("FAIL %s gap%0d: %0d cycles expected %0d", name, ndig, lo_len, GC);
                        end
                    end
                    if (ndig < 10) begin
                        ed = exp_digits[4*ndig +: 4];
                        tests++;
                        if (ifc.out !== ed) begin
                            fails++; $display("FAIL %s digit%0d: got %0d expected %0d", name, ndig, ifc.out, ed);
                        end
                    end
                    ndig++;
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (pc) begin
                    tests++;
                    if (hi_len != HC) begin
                        fails++; $display("FAIL %s hold%0d: %0d cycles expected %0d", name, ndig - 1, hi_len, HC);
                    end
                    lo_len = 0;
                end
                lo_len++;
            end
            if (ifc.done === 1'b1 && done_at < 0) begin
                done_at = cyc;
                tests++;
                if (ifc.busy !== 1'b0 || pb !== 1'b1 || ifc.out !== 4'd0) begin
                    fails++; $display("FAIL %s finish: busy=%b prev_busy=%b out=%0d expected 0 1 0", name, ifc.busy, pb, ifc.out);
                end
            end
            if (toggle_en && cyc == 8)  ifc.enabled = 1'b0;
            if (toggle_en && cyc == 20) ifc.enabled = 1'b1;
            pc = ifc.controlOut;
            pb = ifc.busy;
        end
        tests++;
        if (done_at != exp_done) begin
            fails++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_done);
        end
        tests++;
        if (ndig != exp_cnt) begin
            fails++; $display("FAIL %s digit_count: got %0d expected %0d", name, ndig, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.num = 32'd0;  ifc.enabled = 1'b0;  ifc.abort = 1'b0;
        ifc3.num = 32'd0; ifc3.enabled = 1'b0; ifc3.abort = 1'b0;
        repeat (3) @(posedge hwclk);
        #1;
        tests++;
        if (ifc.out !== 4'd0 || ifc.controlOut !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: out=%0d ctrl=%b busy=%b done=%b expected all 0",
                              ifc.out, ifc.controlOut, ifc.busy, ifc.done);
        end
        @(negedge hwclk); rst = 1'b0;
        @(posedge hwclk); #1;
        tests++;
        if (ifc.busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle: busy=%b expected 0", ifc.busy);
        end
    endtask

    task automatic test_basic();
        run_xfer("basic", 32'd123456, 40'h0000123456, 6, 69, 1'b0, 1'b0);
    endtask

    task automatic test_idle_abort();
        @(negedge hwclk); ifc.abort = 1'b1;
        @(posedge hwclk); #1;
        tests++;
        if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
            fails++; $display("FAIL idle_abort: done=%b busy=%b expected done=1 busy=0", ifc.done, ifc.busy);
        end
        @(negedge hwclk); ifc.abort = 1'b0;
    endtask

    task automatic test_small();
        run_xfer("small42", 32'd42, 40'h0000000042, LZ ? 2 : 6, LZ ? 45 : 69, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        run_xfer("zero", 32'd0, 40'h0, LZ ? 1 : 6, LZ ? 39 : 69, 1'b0, 1'b0);
    endtask

    task automatic test_truncate();
        run_xfer("truncate", 32'd1234567, 40'h0000234567, 6, 69, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_xfer("busy_ignore", 32'd123456, 40'h0000123456, 6, 69, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        int   rises = 0;
        logic pc = 1'b0;
        bit   hit = 1'b0;
        @(negedge hwclk); ifc.enabled = 1'b0;
        @(negedge hwclk); ifc.num = 32'd123456; ifc.enabled = 1'b1;
        for (int c = 0; c < 150 && !hit; c++) begin
            @(posedge hwclk); #1;
            if (ifc.controlOut && !pc) rises++;
            pc = ifc.controlOut;
            if (rises == 2) hit = 1'b1;
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL abort_reach_hold2: strobes seen %0d expected 2", rises);
        end
        @(negedge hwclk); ifc.abort = 1'b1;
        @(posedge hwclk); #1;
        tests++;
        if (ifc.out !== 4'd0 || ifc.controlOut !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            fails++; $display("FAIL abort_outputs: out=%0d ctrl=%b busy=%b done=%b expected all 0",
                              ifc.out, ifc.controlOut, ifc.busy, ifc.done);
        end
        @(negedge hwclk); ifc.abort = 1'b0;
        run_xfer("abort_restart", 32'd123456, 40'h0000123456, 6, 69, 1'b0, 1'b0);
    endtask

    task automatic test_start_wins();
        @(negedge hwclk); ifc.enabled = 1'b0;
        @(negedge hwclk); ifc.enabled = 1'b1; ifc.abort = 1'b1; ifc.num = 32'd7;
        @(posedge hwclk); #1;
        tests++;
        if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
            fails++; $display("FAIL start_wins: busy=%b done=%b expected busy=1 done=0", ifc.busy, ifc.done);
        end
        @(posedge hwclk); #1;
        tests++;
        if (ifc.busy !== 1'b0) begin
            fails++; $display("FAIL start_then_abort: busy=%b expected 0", ifc.busy);
        end
        @(negedge hwclk); ifc.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic pc = 1'b0;
        bit   hit = 1'b0;
        @(negedge hwclk); ifc.enabled = 1'b0;
        @(negedge hwclk); ifc.num = 32'd123456; ifc.enabled = 1'b1;
        for (int c = 0; c < 150 && !hit; c++) begin
            @(posedge hwclk); #1;
            if (pc && !ifc.controlOut) hit = 1'b1;
            pc = ifc.controlOut;
        end
        tests++;
        if (!hit || ifc.busy !== 1'b1 || ifc.out !== 4'd6) begin
            fails++; $display("FAIL reset_mid_reach_gap: reached=%b busy=%b out=%0d expected 1 1 6", hit, ifc.busy, ifc.out);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (ifc.out !== 4'd0 || ifc.controlOut !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            fails++; $display("FAIL reset_mid_async: out=%0d ctrl=%b busy=%b done=%b expected all 0",
                              ifc.out, ifc.controlOut, ifc.busy, ifc.done);
        end
        repeat (2) @(posedge hwclk);
        run_xfer("reset_release", 32'd123456, 40'h0000123456, 6, 69, 1'b1, 1'b0);
    endtask

    task automatic test_digit_w3();
        int         rises = 0;
        logic       pc = 1'b0;
        logic [2:0] seen [2];
        seen[0] = 3'd7; seen[1] = 3'd7;
        @(negedge hwclk); ifc3.num = 32'd98; ifc3.enabled = 1'b1;
        for (int c = 0; c < 150 && rises < 2; c++) begin
            @(posedge hwclk); #1;
            if (ifc3.controlOut && !pc) begin
                seen[rises] = ifc3.out;
                rises++;
            end
            pc = ifc3.controlOut;
        end
        tests++;
        if (seen[0] !== 3'd0) begin
            fails++; $display("FAIL w3_digit0: got %0d expected 0", seen[0]);
        end
        tests++;
        if (seen[1] !== 3'd1) begin
            fails++; $display("FAIL w3_digit1: got %0d expected 1", seen[1]);
        end
        @(negedge hwclk); ifc3.abort = 1'b1;
        @(negedge hwclk); ifc3.abort = 1'b0; ifc3.enabled = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_abort();
        test_small();
        test_zero();
        test_truncate();
        test_busy_ignore();
        test_abort();
        test_start_wins();
        test_reset_mid();
        test_digit_w3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/digit_stream_tx.md
DIGIT_STREAM_TX -- requirements
Module: digit_stream_tx

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 6, meaning decimal digits transmitted per number (legal 1..10).
REQ-002 SHALL provide parameter DIGIT_W, default 4, meaning width of the digit output bus (legal 1..4; digit bits above DIGIT_W are dropped).
REQ-003 SHALL provide parameter HOLD_CYCLES, default 1200000, meaning hwclk cycles controlOut stays high per digit (legal >=1).
REQ-004 SHALL provide parameter GAP_CYCLES, default 1200000, meaning hwclk cycles controlOut stays low between digits (legal >=0; 0 skips GAP).
REQ-005 SHALL have port hwclk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-007 SHALL have port num  input  32  unsigned binary value to transmit, sampled on accepted start.
REQ-008 SHALL have port enabled  input  1  level request; rising edge while idle starts a transfer.
REQ-009 SHALL have port abort  input  1  synchronous cancel of an in-progress transfer.
REQ-010 SHALL have port out  output  DIGIT_W  current digit value, least-significant digit first.
REQ-011 SHALL have port controlOut  output  1  strobe, high while out is valid for the receiver.
REQ-012 SHALL have port busy  output  1  high from accepted start until return to IDLE.
REQ-013 SHALL have port done  output  1  high after a completed transfer until next accepted start.

Function
REQ-014 SHALL implement states IDLE, CONVERT, HOLD, GAP; encoding free.
REQ-015 SHALL detect rising edge of enabled with a registered previous value; edge seen in IDLE = accepted start at cycle 0; edges outside IDLE ignored.
REQ-016 On accepted start SHALL latch num, clear done, set busy, enter CONVERT.
REQ-017 CONVERT SHALL run sequential binary-to-BCD (shift-add-3) over exactly 32 cycles producing 10 BCD digits; only lower NUM_DIGITS digits kept (num mod 10^NUM_DIGITS).
REQ-018 HOLD SHALL drive out = digit[k][DIGIT_W-1:0], controlOut=1, for exactly HOLD_CYCLES cycles, k starting at 0 (units).
REQ-019 GAP SHALL hold out unchanged, controlOut=0, for GAP_CYCLES cycles, then increment k and enter HOLD if digits remain, else IDLE.
REQ-020 On leaving final digit SHALL set done=1, busy=0, out=0 in the same edge; without early termination done rises 1+32+NUM_DIGITS*(HOLD_CYCLES+GAP_CYCLES) cycles after cycle 0.
REQ-021 abort=1 in any non-IDLE state SHALL force IDLE at next edge with out=0, controlOut=0, busy=0, done=0; abort in IDLE has no effect.
REQ-022 abort and an enabled edge in the same IDLE cycle: start SHALL win.
REQ-023 out SHALL be 0 whenever state is IDLE or CONVERT.
REQ-024 Hold/gap counter SHALL be wide enough for max(HOLD_CYCLES,GAP_CYCLES) without wrap.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, out=0, controlOut=0, busy=0, done=0, digit index 0, previous-enabled=0, regardless of clock.
REQ-026 Reset mid-transfer SHALL discard the transfer; enabled held high through reset release SHALL count as a rising edge.

Configuration
REQ-027 Macro DIGIT_STREAM_LZ_SUPPRESS_EN defined: transfer SHALL end after the most-significant nonzero kept digit (at least one digit, so num mod 10^NUM_DIGITS = 0 sends a single 0); undefined: exactly NUM_DIGITS digits always sent.

Verification (NUM_DIGITS=6, DIGIT_W=4, HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-028 num=123456, enabled rise, macro off -> out sequence 6,5,4,3,2,1, each with controlOut high 4 cycles and 2-cycle gap; done rises at cycle 69, busy falls same cycle.
REQ-029 num=42, macro off -> 2,4,0,0,0,0, done at cycle 69; macro on -> 2,4 only, done at cycle 45.
REQ-030 num=0, macro on -> single digit 0 with 4-cycle strobe, done at cycle 39.
REQ-031 num=1234567 -> 7,6,5,4,3,2 (truncated); DIGIT_W=3 with num=98 -> out 0 then 1 (digits 8,9 masked).
REQ-032 abort pulsed during 2nd HOLD -> next edge out=0, controlOut=0, busy=0, done=0; new enabled rise restarts from units digit.
REQ-033 rst asserted between clock edges during GAP -> all outputs 0 before next edge; second enabled rise while busy ignored (no restart, identical sequence).
